noc_core_adapter: RTL



---
 rtl/noc_core_adapter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/noc_core_adapter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | noc_core_adapter                                                      |
// | Core <-> mesh router local-port adapter: TX flit serializer, RX buffer|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module noc_core_adapter #(
   parameter int FLIT_W  = 32,
   parameter int DATA_W  = 30,
   parameter int COORD_W = 2,
   parameter int LEN_W   = 4,
   parameter int MAX_LEN = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] node_x,
   input  logic [COORD_W-1:0] node_y,
   input  logic               tx_hdr_valid,
   output logic               tx_hdr_ready,
   input  logic [COORD_W-1:0] tx_dst_x,
   input  logic [COORD_W-1:0] tx_dst_y,
   input  logic [LEN_W-1:0]   tx_len,
   input  logic               tx_data_valid,
   output logic               tx_data_ready,
   input  logic [DATA_W-1:0]  tx_data,
   output logic [FLIT_W-1:0]  net_flit_out,
   input  logic               net_ready,
   input  logic [FLIT_W-1:0]  net_flit_in,
   output logic               net_accept,
   output logic               rx_valid,
   input  logic               rx_ready,
   output logic [DATA_W-1:0]  rx_data,
   output logic [COORD_W-1:0] rx_src_x,
   output logic [COORD_W-1:0] rx_src_y,
   output logic               rx_last,
   output logic               rx_err
);

   localparam int IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int PTR_W     = $clog2(MAX_LEN + 1);
   localparam int CMP_W     = (LEN_W > PTR_W) ? LEN_W : PTR_W;
   localparam int PAD_W     = FLIT_W - 2 - 4*COORD_W - LEN_W;
   localparam int P_TOP     = FLIT_W - 3;
   localparam int SRC_Y_HI  = P_TOP - 2*COORD_W;
   localparam int SRC_X_HI  = P_TOP - 3*COORD_W;
   localparam int LEN_HI    = P_TOP - 4*COORD_W;

   localparam logic [1:0] FT_HEAD = 2'b01;
   localparam logic [1:0] FT_BODY = 2'b10;
   localparam logic [1:0] FT_TAIL = 2'b11;

   typedef enum logic [1:0] {T_IDLE = 2'd0, T_HEAD = 2'd1, T_DATA = 2'd2} tx_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_COLLECT = 2'd1, R_DELIVER = 2'd2} rx_state_t;

   // ---------------- TX path ----------------
   tx_state_t          tx_state_q;
   logic [COORD_W-1:0] tx_dst_x_q, tx_dst_y_q, tx_src_x_q, tx_src_y_q;
   logic [LEN_W-1:0]   tx_len_q, tx_cnt_q;
   logic [FLIT_W-1:0]  flit_out_q;
   logic               hdr_hs, data_hs, len_bad;

   assign tx_hdr_ready  = (tx_state_q == T_IDLE);
   assign tx_data_ready = (tx_state_q == T_DATA) && net_ready;
   assign net_flit_out  = flit_out_q;
   assign hdr_hs        = tx_hdr_valid && tx_hdr_ready;
   assign data_hs       = tx_data_valid && tx_data_ready;
   assign len_bad       = (tx_len == '0) || (tx_len > LEN_W'(MAX_LEN));

   // net_flit_out defaults to idle each cycle so every flit is a one-cycle pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_q <= T_IDLE;
         flit_out_q <= '0;
         tx_cnt_q   <= '0;
         tx_len_q   <= '0;
         tx_dst_x_q <= '0;
         tx_dst_y_q <= '0;
         tx_src_x_q <= '0;
         tx_src_y_q <= '0;
      end else begin
         flit_out_q <= '0;
         case (tx_state_q)
            T_IDLE: begin
               if (hdr_hs && !len_bad) begin
                  tx_dst_x_q <= tx_dst_x;
                  tx_dst_y_q <= tx_dst_y;
                  tx_src_x_q <= node_x;
                  tx_src_y_q <= node_y;
                  tx_len_q   <= tx_len;
                  tx_cnt_q   <= '0;
                  tx_state_q <= T_HEAD;
               end
            end
            T_HEAD: begin
               if (net_ready) begin
                  flit_out_q <= {FT_HEAD, tx_dst_y_q, tx_dst_x_q, tx_src_y_q,
                                 tx_src_x_q, tx_len_q, {PAD_W{1'b0}}};
                  tx_state_q <= T_DATA;
               end
            end
            T_DATA: begin
               if (data_hs) begin
                  if (tx_cnt_q == tx_len_q - LEN_W'(1)) begin
                     flit_out_q <= {FT_TAIL, tx_data};
                     tx_state_q <= T_IDLE;
                  end else begin
                     flit_out_q <= {FT_BODY, tx_data};
                     tx_cnt_q   <= tx_cnt_q + LEN_W'(1);
                  end
               end
            end
            default: tx_state_q <= T_IDLE;
         endcase
      end
   end

   // ---------------- RX path ----------------
   rx_state_t          rx_state_q;
   logic [DATA_W-1:0]  buf_q [MAX_LEN];
   logic [PTR_W-1:0]   wptr_q, rptr_q, cnt_q;
   logic [LEN_W-1:0]   rx_len_q;
   logic [COORD_W-1:0] rx_src_x_q, rx_src_y_q;
   logic               err_q;
   logic [1:0]         in_type;
   logic               in_head, in_body, in_tail, room, wr_en, rx_hs;
   logic [PTR_W-1:0]   rx_rcv;

   assign in_type = net_flit_in[FLIT_W-1 -: 2];
   assign in_head = (in_type == FT_HEAD);
   assign in_body = (in_type == FT_BODY);
   assign in_tail = (in_type == FT_TAIL);
   assign room    = (wptr_q < PTR_W'(MAX_LEN));
   assign wr_en   = (rx_state_q == R_COLLECT) && (in_body || in_tail) && room;
   assign rx_rcv  = room ? (wptr_q + PTR_W'(1)) : wptr_q;
   assign rx_hs   = rx_valid && rx_ready;

   assign net_accept = (rx_state_q != R_DELIVER);
   assign rx_valid   = (rx_state_q == R_DELIVER);
   assign rx_data    = rx_valid ? buf_q[rptr_q[IDX_W-1:0]] : '0;
   assign rx_last    = (rptr_q == cnt_q - PTR_W'(1));
   assign rx_src_x   = rx_src_x_q;
   assign rx_src_y   = rx_src_y_q;
   assign rx_err     = err_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_q[wptr_q[IDX_W-1:0]] <= net_flit_in[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state_q <= R_IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         rx_len_q   <= '0;
         rx_src_x_q <= '0;
         rx_src_y_q <= '0;
         err_q      <= 1'b0;
      end else begin
         // A rejected TX header is reported through the shared error flag
         if (hdr_hs && len_bad) begin
            err_q <= 1'b1;
         end
         case (rx_state_q)
            R_IDLE: begin
               if (in_head) begin
                  rx_src_x_q <= net_flit_in[SRC_X_HI -: COORD_W];
                  rx_src_y_q <= net_flit_in[SRC_Y_HI -: COORD_W];
                  rx_len_q   <= net_flit_in[LEN_HI -: LEN_W];
                  wptr_q     <= '0;
                  rx_state_q <= R_COLLECT;
               end else if (in_body || in_tail) begin
                  err_q <= 1'b1;
               end
            end
            R_COLLECT: begin
               if (in_head) begin
                  err_q      <= 1'b1;
                  rx_src_x_q <= net_flit_in[SRC_X_HI -: COORD_W];
                  rx_src_y_q <= net_flit_in[SRC_Y_HI -: COORD_W];
                  rx_len_q   <= net_flit_in[LEN_HI -: LEN_W];
                  wptr_q     <= '0;
               end else if (in_body) begin
                  if (room) begin
                     wptr_q <= wptr_q + PTR_W'(1);
                  end else begin
                     err_q <= 1'b1;
                  end
               end else if (in_tail) begin
                  if (!room || (CMP_W'(rx_rcv) != CMP_W'(rx_len_q))) begin
                     err_q <= 1'b1;
                  end
                  cnt_q      <= rx_rcv;
                  rptr_q     <= '0;
                  rx_state_q <= R_DELIVER;
               end
            end
            R_DELIVER: begin
               if (net_flit_in != '0) begin
                  err_q <= 1'b1;
               end
               if (rx_hs) begin
                  if (rx_last) begin
                     rptr_q     <= '0;
                     rx_state_q <= R_IDLE;
                  end else begin
                     rptr_q <= rptr_q + PTR_W'(1);
                  end
               end
            end
            default: rx_state_q <= R_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
